// File: rtl/bg_mean_estimator_pkg.sv
// Shared definitions for the background mean estimator.
//   PIX_W       bits per colour channel
//   MAX_PIXELS  largest calibration set per estimate
//   CNT_W       pixel counter width (holds 0..MAX_PIXELS)
//   SUM_W       accumulator / dividend width
//   state_t     one-hot controller state
//   sat_pix()   clamps a quotient to the pixel range
package bg_pkg;

  localparam int PIX_W      = 8;
  localparam int MAX_PIXELS = 4096;
  localparam int CNT_W      = $clog2(MAX_PIXELS + 1);
  localparam int SUM_W      = PIX_W + CNT_W;

  typedef enum logic [3:0] {
    IDLE   = 4'b0001,
    ACCUM  = 4'b0010,
    DIVIDE = 4'b0100,
    DONE   = 4'b1000
  } state_t;

  // A rounded mean of PIX_W-bit samples always fits in PIX_W bits; the clamp
  // only guards against a corrupted accumulator.
  function automatic logic [PIX_W-1:0] sat_pix(input logic [SUM_W-1:0] q);
    if (|q[SUM_W-1:PIX_W]) return {PIX_W{1'b1}};
    return q[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/bg_mean_estimator_seq_divider.sv
// Restoring shift-subtract divider, one quotient bit per clock.
//   Clk, Reset  clock, asynchronous active-high reset
//   start       1-cycle pulse: load dividend and perform the first step
//   dividend    SUM_W-bit numerator (sampled on start only)
//   divisor     CNT_W-bit denominator, non-zero, held stable until done
//   quotient    result, valid when done is high
//   done        1-cycle pulse after the SUM_W-th step
module seq_divider #(
  parameter int SUM_W = 21,
  parameter int CNT_W = 13
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic [SUM_W-1:0] quotient,
  output logic             done
);

  localparam int STEP_W = $clog2(SUM_W + 1);

  // dq_q starts as the dividend and fills with quotient bits from the right
  // as dividend bits are shifted out on the left.
  logic [CNT_W-1:0]  rem_q, rem_in, rem_nxt;
  logic [SUM_W-1:0]  dq_q, dq_in, dq_nxt;
  logic [CNT_W:0]    trial;
  logic [STEP_W-1:0] steps_q;

  // The load cycle also performs step one, so exactly SUM_W clocks elapse.
  always_comb begin
    rem_in = start ? '0 : rem_q;
    dq_in  = start ? dividend : dq_q;
    trial  = {rem_in, dq_in[SUM_W-1]};
    if (trial >= {1'b0, divisor}) begin
      // Remainder stays below divisor, so the difference fits in CNT_W bits.
      rem_nxt = CNT_W'(trial - {1'b0, divisor});
      dq_nxt  = {dq_in[SUM_W-2:0], 1'b1};
    end else begin
      rem_nxt = trial[CNT_W-1:0];
      dq_nxt  = {dq_in[SUM_W-2:0], 1'b0};
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rem_q   <= '0;
      dq_q    <= '0;
      steps_q <= '0;
      done    <= 1'b0;
    end else if (start) begin
      rem_q   <= rem_nxt;
      dq_q    <= dq_nxt;
      steps_q <= STEP_W'(SUM_W - 1);
      done    <= 1'b0;
    end else if (steps_q != '0) begin
      rem_q   <= rem_nxt;
      dq_q    <= dq_nxt;
      steps_q <= steps_q - 1'b1;
      done    <= (steps_q == STEP_W'(1));
    end else begin
      done    <= 1'b0;
    end
  end

  assign quotient = dq_q;

endmodule

// File: rtl/bg_mean_estimator.sv
// Background mean estimator: accumulates a calibration stream of RGB pixels
// and produces the rounded per-channel mean for the background-removal PE.
//   Clk, Reset            clock, asynchronous active-high reset
//   Start                 begin a new estimate (IDLE only)
//   pix_valid/pix_ready   pixel handshake; pix_r/g/b data, pix_last ends set
//   exp_red/green/blue    expected background colour, held until next result
//   exp_valid             result present, held until Ack
//   Ack                   consumer took the result (DONE only)
//   Busy                  accumulating or dividing
//   Overflow              sticky: set hit MAX_PIXELS without pix_last
module bg_mean_estimator
  import bg_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [PIX_W-1:0] pix_r,
  input  logic [PIX_W-1:0] pix_g,
  input  logic [PIX_W-1:0] pix_b,
  input  logic             pix_last,
  output logic [PIX_W-1:0] exp_red,
  output logic [PIX_W-1:0] exp_green,
  output logic [PIX_W-1:0] exp_blue,
  output logic             exp_valid,
  input  logic             Ack,
  output logic             Busy,
  output logic             Overflow
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count, count_inc;
  logic [SUM_W-1:0] sum_r, sum_g, sum_b;
  logic             xfer, hit_max, end_of_set;
  logic             div_start;
  logic             done_r, done_g, done_b;
  logic [SUM_W-1:0] quo_r, quo_g, quo_b;
  logic [SUM_W-1:0] half_count;

  assign xfer       = pix_valid & pix_ready;
  assign count_inc  = count + 1'b1;
  assign hit_max    = (count_inc == CNT_W'(MAX_PIXELS));
  assign end_of_set = xfer & (pix_last | hit_max);
  // Adding count/2 before truncating division rounds to nearest.
  assign half_count = SUM_W'(count >> 1);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first so no path through
  // the case statement can leave a latch behind.
  always_comb begin
    state_nxt = state;
    pix_ready = 1'b0;
    exp_valid = 1'b0;
    Busy      = 1'b0;
    unique case (state)
      IDLE:   if (Start) state_nxt = ACCUM;
      ACCUM: begin
        pix_ready = 1'b1;
        Busy      = 1'b1;
        if (end_of_set) state_nxt = DIVIDE;
      end
      DIVIDE: begin
        Busy = 1'b1;
        if (done_r) state_nxt = DONE;
      end
      DONE: begin
        exp_valid = 1'b1;
        // Ack takes priority; a simultaneous Start is dropped.
        if (Ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count     <= '0;
      sum_r     <= '0;
      sum_g     <= '0;
      sum_b     <= '0;
      Overflow  <= 1'b0;
      div_start <= 1'b0;
      exp_red   <= '0;
      exp_green <= '0;
      exp_blue  <= '0;
    end else begin
      div_start <= 1'b0;
      if ((state == IDLE) && Start) begin
        count    <= '0;
        sum_r    <= '0;
        sum_g    <= '0;
        sum_b    <= '0;
        Overflow <= 1'b0;
      end
      if (xfer) begin
        count     <= count_inc;
        sum_r     <= sum_r + SUM_W'(pix_r);
        sum_g     <= sum_g + SUM_W'(pix_g);
        sum_b     <= sum_b + SUM_W'(pix_b);
        div_start <= end_of_set;
        if (hit_max && !pix_last) Overflow <= 1'b1;
      end
      // The three dividers run in lockstep; each channel latches on its own done.
      if (state == DIVIDE) begin
        if (done_r) exp_red   <= sat_pix(quo_r);
        if (done_g) exp_green <= sat_pix(quo_g);
        if (done_b) exp_blue  <= sat_pix(quo_b);
      end
    end
  end

  // Dividers start the cycle after the final transfer, when sums and count
  // already include the last pixel.
  seq_divider #(.SUM_W(SUM_W), .CNT_W(CNT_W)) u_div_r (
    .Clk(Clk), .Reset(Reset), .start(div_start),
    .dividend(sum_r + half_count), .divisor(count),
    .quotient(quo_r), .done(done_r)
  );

  seq_divider #(.SUM_W(SUM_W), .CNT_W(CNT_W)) u_div_g (
    .Clk(Clk), .Reset(Reset), .start(div_start),
    .dividend(sum_g + half_count), .divisor(count),
    .quotient(quo_g), .done(done_g)
  );

  seq_divider #(.SUM_W(SUM_W), .CNT_W(CNT_W)) u_div_b (
    .Clk(Clk), .Reset(Reset), .start(div_start),
    .dividend(sum_b + half_count), .divisor(count),
    .quotient(quo_b), .done(done_b)
  );

endmodule
